multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; every state update occurs on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port op, input, 7, the opcode field from the instruction register.
REQ-004 SHALL have port func3, input, 3, the func3 field from the instruction register.
REQ-005 SHALL have ports zero and neg, input, 1 each, ALU result-zero and signed-less-than flags, valid in the BRANCH cycle.
REQ-006 SHALL have port PCWrite, output, 1, PC register load enable.
REQ-007 SHALL have port AdrSrc, output, 1, memory address select: 0 = PC, 1 = ALUOut.
REQ-008 SHALL have ports MemWrite and IRWrite, output, 1 each, data-memory write enable and instruction/OldPC register load enable.
REQ-009 SHALL have port RegWrite, output, 1, register-file write enable.
REQ-010 SHALL have port ResultSrc, output, 2: 00 = ALUOut, 01 = memory data register, 10 = ALU result, 11 = immediate.
REQ-011 SHALL have ports ALUSrcA and ALUSrcB, output, 2 each. ALUSrcA: 00 = PC, 01 = OldPC, 10 = rs1 register. ALUSrcB: 00 = rs2 register, 01 = immediate, 10 = constant 4.
REQ-012 SHALL have port ALUOp, output, 2, driving the ALU controller: 00 = add, 01 = subtract, 10 = R-type decode, 11 = I-type decode.
REQ-013 SHALL have port ImmSrc, output, 3, combinational from op: I-format 000, S 001, B 010, J 011, U 100, other 000.

Function
REQ-014 SHALL be a Moore FSM; all outputs are decoded from the state register, except the PCWrite branch term, ImmSrc and next-state logic.
REQ-015 SHALL treat every output not listed for a state as 0 or 00.
REQ-016 FETCH SHALL drive:
- AdrSrc=0, IRWrite=1.
- ALUSrcA=00, ALUSrcB=10, ALUOp=00.
- ResultSrc=10, PCWrite=1.
- Next state: DECODE.
REQ-017 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00, precomputing the branch/jal target into ALUOut. Next state by op:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECR.
- 0010011 -> EXECI.
- 1100011 -> BRANCH.
- 1101111 -> JAL.
- 1100111 -> JALR.
- 0110111 -> LUI.
- Any other op -> FETCH, with no write enable asserted.
REQ-018 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state is MEMREAD if op=0000011, else MEMWRITE.
REQ-019 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00; next state MEMWB.
REQ-020 MEMWB SHALL drive ResultSrc=01, RegWrite=1; next state FETCH.
REQ-021 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1; next state FETCH.
REQ-022 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=11; both go next to ALUWB.
REQ-023 ALUWB SHALL drive ResultSrc=00, RegWrite=1; next state FETCH.
REQ-024 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; next state FETCH.
- PCWrite = zero when func3=000.
- PCWrite = ~zero when func3=001.
- PCWrite = neg when func3=100.
- PCWrite = ~neg when func3=101.
- PCWrite = 0 for any other func3.
REQ-025 JALR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, overwriting ALUOut with rs1+imm; next state JAL.
REQ-026 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; next state ALUWB, which writes OldPC+4 to rd.
REQ-027 LUI SHALL drive ResultSrc=11, RegWrite=1; next state FETCH.
REQ-028 Instruction latency, FETCH through return to FETCH, SHALL be:
- lw 5 cycles; jalr 5.
- sw 4; R-type 4; I-type 4; jal 4.
- branch 3; lui 3.
- Undefined op 2.
REQ-029 SHALL never assert MemWrite and RegWrite in the same cycle, and SHALL never assert IRWrite outside FETCH.
REQ-030 SHALL use unreachable state encodings that go to FETCH on the next edge with all enables 0.

Reset
REQ-031 rst_n low SHALL force the state to FETCH immediately, regardless of clk, including mid-instruction; any partially executed instruction is abandoned.
REQ-032 While rst_n is low, all write enables (PCWrite, IRWrite, MemWrite, RegWrite) SHALL be 0; the FETCH select values remain driven.
REQ-033 The first rising clk edge after rst_n deasserts SHALL perform the FETCH actions and enter DECODE.

Verification
REQ-034 lw (op=0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 only in the 5th cycle.
REQ-035 beq (op=1100011, func3=000):
- zero=1 -> PCWrite=1 in BRANCH with ALUOp=01.
- zero=0 -> PCWrite=0.
- Both cases return to FETCH after 3 cycles.
REQ-036 jalr (op=1100111) -> JALR then JAL (PCWrite=1, ALUSrcB=10) then ALUWB (RegWrite=1, ResultSrc=00).
REQ-037 R-type then I-type -> ALUOp=10 in EXECR, ALUOp=11 in EXECI; each is 4 cycles.
REQ-038 Undefined op=1111111 -> DECODE then FETCH with no enable asserted; then rst_n pulsed low in MEMADR of a sw -> immediate FETCH, MemWrite never 1.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a multicycle RV32I-subset datapath.
// Write enables are forced low while rst_n is held; select outputs follow the state register.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read instruction at PC, latch IR/OldPC, PC <= PC + 4
// DECODE   | ALUOut <= OldPC + imm (branch/jal target), dispatch on op
// MEMADR   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= memory data register
// MEMWRITE | write rs2 to data memory at ALUOut
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
// JALR     | ALUOut <= rs1 + imm, overwriting the DECODE target
// JAL      | PC <= ALUOut, ALUOut <= OldPC + 4
// LUI      | rd <= immediate
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JAL      = 4'd11,
    S_LUI      = 4'd12
  } state_t;

  state_t state_q, state_d;

  logic pc_write_s, adr_src_s, mem_write_s, ir_write_s, reg_write_s;
  logic branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (func3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = neg;
      3'b101:  branch_taken = ~neg;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_write_s  = 1'b0;
    adr_src_s   = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: adr_src_s = 1'b1;
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b11;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        pc_write_s = branch_taken;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_s = 1'b1;
      end
      S_LUI: begin
        ResultSrc   = 2'b11;
        reg_write_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by rst_n so nothing is written while reset is held.
  assign PCWrite  = pc_write_s  & rst_n;
  assign IRWrite  = ir_write_s  & rst_n;
  assign MemWrite = mem_write_s & rst_n;
  assign RegWrite = reg_write_s & rst_n;
  assign AdrSrc   = adr_src_s;

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction control-word
// sequences compared against a table-driven model of each instruction class.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] func3;
  logic       zero, neg;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .zero(zero), .neg(neg),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc)
  );

  always #5 clk = ~clk;

  logic [12:0] obs_w;
  assign obs_w = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

  int tests = 0;
  int fails = 0;
  logic [12:0] obs_q[$];
  logic [12:0] exp_q[$];
  logic [2:0]  imm_q[$];
  bit          timed_out;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111;
  logic [6:0] valid_ops [8] = '{LW, SW, RT, IT, BR, JL, JR, LU};

  // Control word: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
  function automatic logic [12:0] cw(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, a, b, aop);
    return {pcw, adr, mw, irw, rw, rs, a, b, aop};
  endfunction

  function automatic logic [2:0] imm_model(input logic [6:0] o);
    case (o)
      SW:                    return 3'b001;
      BR:                    return 3'b010;
      JL:                    return 3'b011;
      LU, 7'b0010111:        return 3'b100;
      default:               return 3'b000;
    endcase
  endfunction

  // Expected per-cycle control words of one instruction, FETCH first.
  function automatic void build_exp(input logic [6:0] o, input logic [2:0] f, input logic z, n);
    logic taken;
    logic [12:0] alu_wb, jal_w;
    alu_wb = cw(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00);
    jal_w  = cw(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00);
    taken  = (f == 3'd0 && z) || (f == 3'd1 && !z) || (f == 3'd4 && n) || (f == 3'd5 && !n);
    exp_q.delete();
    exp_q.push_back(cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00));
    exp_q.push_back(cw(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00));
    case (o)
      LW: begin
        exp_q.push_back(cw(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00));
        exp_q.push_back(cw(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00));
        exp_q.push_back(cw(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00));
      end
      SW: begin
        exp_q.push_back(cw(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00));
        exp_q.push_back(cw(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00));
      end
      RT: begin
        exp_q.push_back(cw(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10));
        exp_q.push_back(alu_wb);
      end
      IT: begin
        exp_q.push_back(cw(0,0,0,0,0,2'b00,2'b10,2'b01,2'b11));
        exp_q.push_back(alu_wb);
      end
      BR: exp_q.push_back(cw(taken,0,0,0,0,2'b00,2'b10,2'b00,2'b01));
      JL: begin
        exp_q.push_back(jal_w);
        exp_q.push_back(alu_wb);
      end
      JR: begin
        exp_q.push_back(cw(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00));
        exp_q.push_back(jal_w);
        exp_q.push_back(alu_wb);
      end
      LU: exp_q.push_back(cw(0,0,0,0,1,2'b11,2'b00,2'b00,2'b00));
      default: ;
    endcase
  endfunction

  // Entered in the low half of a FETCH cycle; returns in the low half of the next FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic z, n);
    bit back;
    op = o; func3 = f; zero = z; neg = n;
    obs_q.delete(); imm_q.delete();
    back = 0;
    #1;
    obs_q.push_back(obs_w);
    imm_q.push_back(ImmSrc);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (IRWrite === 1'b1) begin
        back = 1;
        break;
      end
      obs_q.push_back(obs_w);
      imm_q.push_back(ImmSrc);
    end
    timed_out = !back;
  endtask

  task automatic test_reset();
    logic [12:0] rst_w, fetch_w;
    rst_w   = cw(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00);
    fetch_w = cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      tests++;
      if (obs_w !== rst_w) begin
        fails++;
        $display("FAIL reset_hold[%0d] got %b want %b", i, obs_w, rst_w);
      end
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (obs_w !== fetch_w) begin
      fails++;
      $display("FAIL reset_release got %b want %b", obs_w, fetch_w);
    end
  endtask

  task automatic test_lw();
    build_exp(LW, 3'b010, 1'b0, 1'b0);
    run_instr(LW, 3'b010, 1'b0, 1'b0);
    tests++;
    if (timed_out || obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL lw_latency got %0d cycles (timeout=%0d) want %0d", obs_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL lw_cycle%0d got %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3 [6] = '{3'd0, 3'd0, 3'd1, 3'd4, 3'd5, 3'd2};
    logic       zz [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       nn [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 6; c++) begin
      build_exp(BR, f3[c], zz[c], nn[c]);
      run_instr(BR, f3[c], zz[c], nn[c]);
      tests++;
      if (timed_out || obs_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL branch%0d_latency got %0d cycles want %0d", c, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL branch%0d_cycle%0d got %b want %b", c, i, obs_q[i], exp_q[i]);
        end
      end
      tests++;
      if (imm_q[0] !== 3'b010) begin
        fails++;
        $display("FAIL branch%0d_immsrc got %b want 010", c, imm_q[0]);
      end
    end
  endtask

  task automatic test_jalr();
    build_exp(JR, 3'b000, 1'b0, 1'b0);
    run_instr(JR, 3'b000, 1'b0, 1'b0);
    tests++;
    if (timed_out || obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL jalr_latency got %0d cycles want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL jalr_cycle%0d got %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_r_i();
    logic [6:0] ops [2] = '{RT, IT};
    for (int c = 0; c < 2; c++) begin
      build_exp(ops[c], 3'b000, 1'b0, 1'b0);
      run_instr(ops[c], 3'b000, 1'b0, 1'b0);
      tests++;
      if (timed_out || obs_q.size() != 4) begin
        fails++;
        $display("FAIL ri%0d_latency got %0d cycles want 4", c, obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL ri%0d_cycle%0d got %b want %b", c, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_undef_and_reset();
    logic [12:0] rst_w;
    rst_w = cw(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00);
    build_exp(7'b1111111, 3'b000, 1'b1, 1'b1);
    run_instr(7'b1111111, 3'b000, 1'b1, 1'b1);
    tests++;
    if (timed_out || obs_q.size() != 2) begin
      fails++;
      $display("FAIL undef_latency got %0d cycles want 2", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL undef_cycle%0d got %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
    // sw abandoned by reset while in MEMADR
    build_exp(SW, 3'b010, 1'b0, 1'b0);
    op = SW; func3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      #1;
      tests++;
      if (obs_w !== exp_q[i]) begin
        fails++;
        $display("FAIL sw_pre_reset_cycle%0d got %b want %b", i, obs_w, exp_q[i]);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (obs_w !== rst_w) begin
      fails++;
      $display("FAIL sw_async_reset got %b want %b", obs_w, rst_w);
    end
    @(posedge clk); #1;
    tests++;
    if (obs_w !== rst_w || MemWrite !== 1'b0) begin
      fails++;
      $display("FAIL sw_reset_held got %b want %b", obs_w, rst_w);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (obs_w !== exp_q[0]) begin
      fails++;
      $display("FAIL sw_after_reset got %b want %b", obs_w, exp_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 8; c++) begin
      build_exp(valid_ops[c], 3'b101, 1'b0, 1'b0);
      run_instr(valid_ops[c], 3'b101, 1'b0, 1'b0);
      tests++;
      if (timed_out || obs_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL b2b%0d_latency got %0d cycles want %0d", c, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL b2b%0d_cycle%0d got %b want %b", c, i, obs_q[i], exp_q[i]);
        end
      end
      tests++;
      if (imm_q[0] !== imm_model(valid_ops[c])) begin
        fails++;
        $display("FAIL b2b%0d_immsrc got %b want %b", c, imm_q[0], imm_model(valid_ops[c]));
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] o;
    logic [2:0] f;
    logic       z, n;
    for (int c = 0; c < 60; c++) begin
      if ($urandom_range(0, 9) < 8) o = valid_ops[$urandom_range(0, 7)];
      else                          o = 7'($urandom);
      f = 3'($urandom);
      z = 1'($urandom);
      n = 1'($urandom);
      build_exp(o, f, z, n);
      run_instr(o, f, z, n);
      tests++;
      if (timed_out || obs_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL rand%0d_latency op=%b got %0d cycles want %0d", c, o, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL rand%0d_cycle%0d op=%b f3=%b got %b want %b", c, i, o, f, obs_q[i], exp_q[i]);
        end
      end
      tests++;
      if (imm_q[0] !== imm_model(o)) begin
        fails++;
        $display("FAIL rand%0d_immsrc op=%b got %b want %b", c, o, imm_q[0], imm_model(o));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    op = 7'b0; func3 = 3'b0; zero = 1'b0; neg = 1'b0;
    test_reset();
    test_lw();
    test_branch();
    test_jalr();
    test_r_i();
    test_undef_and_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
